uart_tx: RTL
============

# uart_tx

Serial transmitter for the UART test path. It accepts bytes from the message source over an `o_cts`/`i_req` handshake and serializes them onto a single TX line as 8N1 frames with configurable extra stop bits. It reports line idleness back to the source so the source can start a transfer, and it drives the line that feeds the UART receiver / checker downstream.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 3: clock cycles per serial bit; legal range ≥1.
- `EXTRA_STOP_BITS`, default 7: stop bits added after the mandatory one; legal range ≥0.

**Ports**
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `i_data` input 8: byte to send; sampled only on an accept edge.
- `i_req` input 1: the source has a byte valid on `i_data`.
- `o_serial` output 1: TX line; idle high.
- `o_cts` output 1: clear to send; a byte is accepted at any rising edge where `i_req && o_cts`.
- `o_idle` output 1: no frame in progress.

## Operation

- **States:** IDLE, START, DATA, STOP.
- **Registers:**
  - `state`
  - `tick`: down-counter, `CLKS_PER_BIT-1`..0, width `$clog2(CLKS_PER_BIT)` with a minimum of 1.
  - `bit_idx`: 0..7.
  - `stop_cnt`: 0..`EXTRA_STOP_BITS`.
  - `shreg[7:0]`: byte being sent.
- **Outputs** (combinational from registers only; no path from inputs to outputs):
  - `o_serial`: IDLE → 1, START → 0, DATA → `shreg[0]`, STOP → 1.
  - `o_idle` = (state == IDLE).
  - `o_cts` = (state == IDLE) || (state == STOP && `stop_cnt` == `EXTRA_STOP_BITS` && `tick` == 0).
- **Accept** (`i_req && o_cts`):
  - `shreg` ← `i_data`, `tick` ← `CLKS_PER_BIT-1`, `bit_idx` ← 0, `stop_cnt` ← 0.
  - `state` ← START. This applies from both IDLE and the last STOP cycle.
- **Transitions.** Each state holds for `CLKS_PER_BIT` cycles per bit. `tick` decrements each cycle. When `tick` == 0, `tick` reloads and:
  - START → DATA.
  - DATA: `shreg` shifts right by 1 and `bit_idx` increments. When `bit_idx` == 7, go to STOP instead.
  - STOP: `stop_cnt` increments. When `stop_cnt` == `EXTRA_STOP_BITS`, go to IDLE, unless an accept occurs that edge, in which case go to START.
- **Bit order:** LSB first.
- **Non-accepted requests:** `i_req` with `o_cts` low is ignored. Nothing is latched, and the source must hold its request.
- **Reset** (async, any time, including mid-frame):
  - state IDLE; `tick`, `bit_idx`, `stop_cnt`, `shreg` cleared.
  - Outputs go immediately to `o_serial`=1, `o_cts`=1, `o_idle`=1.
  - A partial frame is abandoned and not resumed.

## Timing

- **Frame length:** F = (10 + `EXTRA_STOP_BITS`) × `CLKS_PER_BIT` cycles. Defaults give 17 × 3 = 51.
- **Start of frame:** for an accept at edge t0, `o_serial` goes 0 in the cycle after t0. `o_idle` and `o_cts` drop in that same cycle.
- **Bit windows:** data bit k occupies cycles t0+(1+k)·`CLKS_PER_BIT` through t0+(2+k)·`CLKS_PER_BIT`−1, counted as cycles after edge t0.
- **Back-to-back:** `o_cts` is high for exactly one cycle, the last cycle of the last stop bit. An accept there starts the next start bit with zero extra gap, so consecutive frames are exactly F cycles apart.
- **No back-to-back accept:** the block returns to IDLE, and `o_cts`/`o_idle` are high from edge t0+F onward.
- **Throughput:** at most one byte per F cycles.

## Test plan

- **Reset values.** Assert `rst_n`=0 for 2 cycles, then release. Required: `o_serial`=1, `o_cts`=1, `o_idle`=1, held while `i_req`=0.
- **Single byte, defaults.** Send 0x55. Required: the line reads 0,1,0,1,0,1,0,1,0, then 8 ones, each bit 3 cycles wide. `o_idle` returns to 1 exactly 51 cycles after accept. `o_cts` is high only in cycle 50 of the frame.
- **Back-to-back.** Hold `i_req` with 0xA3, then 0x0F. Required: the second start bit begins at cycle 51 exactly. Exactly 2 accepts occur. The decoded bytes are 0xA3, 0x0F. `o_idle` stays low across the boundary.
- **Request while busy.** Pulse `i_req` with 0xFF for one cycle mid-DATA of byte 0x00. Required: it is ignored. The line carries only 0x00, and no second frame follows.
- **Mid-frame reset.** Assert `rst_n` low during bit 4 of 0x3C. Required: `o_serial`=1 asynchronously and `o_idle`=1. After release, a new byte 0xC3 is framed cleanly, starting from its start bit.
- **Parameter corner.** Set `CLKS_PER_BIT`=1, `EXTRA_STOP_BITS`=0. Send 0xFF then 0x00 back-to-back. Required: 10-cycle frames. The line reads 0,1×8,1 then 0,0×8,1.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serializer with configurable extra stop bits and a cts/req byte handshake.
module uart_tx #(
  parameter int CLKS_PER_BIT    = 3,
  parameter int EXTRA_STOP_BITS = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_req,
  output logic       o_serial,
  output logic       o_cts,
  output logic       o_idle
);
  localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int SW = EXTRA_STOP_BITS > 0 ? $clog2(EXTRA_STOP_BITS + 1) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] STOP_MAX = SW'(EXTRA_STOP_BITS);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [SW-1:0] stop_cnt_q, stop_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic tick_end, accept;
  assign tick_end = tick_q == '0;
  assign o_serial = state_q == START ? 1'b0 : state_q == DATA ? shreg_q[0] : 1'b1;
  assign o_idle   = state_q == IDLE;
  // cts also opens on the final stop-bit cycle so frames can run back-to-back
  assign o_cts    = o_idle || (state_q == STOP && stop_cnt_q == STOP_MAX && tick_end);
  assign accept   = i_req && o_cts;
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    shreg_d    = shreg_q;
    if (accept) begin
      state_d    = START;
      tick_d     = TICK_MAX;
      bit_idx_d  = '0;
      stop_cnt_d = '0;
      shreg_d    = i_data;
    end else if (state_q != IDLE) begin
      tick_d = tick_end ? TICK_MAX : tick_q - TW'(1);
      if (tick_end) begin
        unique case (state_q)
          START: state_d = DATA;
          DATA: begin
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
            state_d   = bit_idx_q == 3'd7 ? STOP : DATA;
          end
          STOP: begin
            stop_cnt_d = stop_cnt_q + SW'(1);
            state_d    = stop_cnt_q == STOP_MAX ? IDLE : STOP;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      shreg_q    <= shreg_d;
    end
  end
endmodule
